dds_sweep_ctrl: RTL and testbench

- Sequencer for the DDS tone generator; drives its FreqCntrl, AmplCntrl and en inputs from a latched sweep descriptor.
- Each run: ramps amplitude up from 0, steps frequency through a programmed linear sweep with fixed dwell per step, then ramps amplitude back to 0 (click-free), and pulses Done.
- Sits on the AXI_clk side between the register bank and the DDS instance.

---
 rtl/dds_sweep_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_sweep_ctrl.sv
//-----------------------------------------------------------------------------
// dds_sweep_ctrl
//
// Sequencer in front of the DDS tone generator. A run is launched from IDLE by
// Start. It latches a sweep descriptor, ramps the amplitude up from zero to a
// plateau, then steps the tuning word through a linear sweep with a fixed dwell
// per frequency. After that it ramps the amplitude back down to zero so the
// tone ends without a click, and finally pulses Done for one cycle.
//
// Abort in RAMP_UP or SWEEP skips straight to the amplitude ramp-down, so an
// aborted run also ends click-free. Reset is the only way to stop
// immediately.
//
// Parameters
//   FREQ_W  width of the tuning word (FreqStart, FreqStep, FreqCntrl)
//   AMPL_W  width of the signed amplitude word (AmplTarget, AmplStep, AmplCntrl)
//   CNT_W   width of StepCount and DwellCycles
//
// Ports
//   AXI_clk      clock, single domain, rising edge
//   rst          synchronous active-high reset
//   Start        launch a run (sampled only in IDLE, ignored with Abort)
//   Abort        early termination through the ramp-down
//   FreqStart    first tuning word of the sweep
//   FreqStep     signed per-step increment, wraps modulo 2^FREQ_W
//   StepCount    number of increments after FreqStart
//   DwellCycles  cycles each frequency is held (0 behaves as 1)
//   AmplTarget   plateau amplitude, values with the sign bit set clamp to max
//   AmplStep     unsigned ramp increment per cycle, 0 means "jump at once"
//   FreqCntrl    tuning word to the DDS
//   AmplCntrl    amplitude to the DDS, never negative
//   DDSEn        DDS enable
//   Busy         high from Start acceptance until the Done cycle
//   Done         one-cycle pulse at the end of a run
//-----------------------------------------------------------------------------
module dds_sweep_ctrl #(
   parameter int FREQ_W = 32,
   parameter int AMPL_W = 16,
   parameter int CNT_W  = 16
) (
   input  logic              AXI_clk,
   input  logic              rst,
   input  logic              Start,
   input  logic              Abort,
   input  logic [FREQ_W-1:0] FreqStart,
   input  logic [FREQ_W-1:0] FreqStep,
   input  logic [CNT_W-1:0]  StepCount,
   input  logic [CNT_W-1:0]  DwellCycles,
   input  logic [AMPL_W-1:0] AmplTarget,
   input  logic [AMPL_W-1:0] AmplStep,
   output logic [FREQ_W-1:0] FreqCntrl,
   output logic [AMPL_W-1:0] AmplCntrl,
   output logic              DDSEn,
   output logic              Busy,
   output logic              Done
);

   // Largest positive amplitude. The DDS multiplies by AmplCntrl as a signed
   // value, so the sign bit must never be driven.
   localparam logic [AMPL_W-1:0] AMPL_MAX = {1'b0, {(AMPL_W-1){1'b1}}};

   typedef enum logic [2:0] {
      IDLE,
      RAMP_UP,
      SWEEP,
      RAMP_DOWN,
      DONE
   } state_t;

   state_t state_q, state_d;

   // Shadow copy of the descriptor. These are loaded once at Start so the
   // register bank may be rewritten while a run is in progress.
   logic [FREQ_W-1:0] freq_step_q;
   logic [CNT_W-1:0]  step_count_q;
   logic [CNT_W-1:0]  dwell_reload_q;   // max(DwellCycles,1)-1
   logic [AMPL_W-1:0] ampl_target_q;    // already clamped to AMPL_MAX
   logic [AMPL_W-1:0] ampl_step_q;      // a step of 0 is stored as AMPL_MAX

   // Sweep counters.
   logic [CNT_W-1:0]  dwell_cnt_q, dwell_cnt_d;
   logic [CNT_W-1:0]  steps_left_q, steps_left_d;

   // Next values of the registered outputs.
   logic [FREQ_W-1:0] freq_d;
   logic [AMPL_W-1:0] ampl_d;
   logic              en_d;
   logic              busy_d;
   logic              done_d;

   // High on the edge that accepts a Start; loads the shadow registers.
   logic              accept;

   // Ramp arithmetic. The up-ramp sum carries one extra bit so that a large
   // step can never wrap around past the target.
   logic [AMPL_W:0]   ampl_sum;
   logic [AMPL_W-1:0] ampl_up;
   logic [AMPL_W-1:0] ampl_dn;

   assign ampl_sum = {1'b0, AmplCntrl} + {1'b0, ampl_step_q};
   assign ampl_up  = (ampl_sum >= {1'b0, ampl_target_q}) ? ampl_target_q
                                                         : ampl_sum[AMPL_W-1:0];
   // The down-ramp saturates at zero instead of underflowing.
   assign ampl_dn  = (ampl_step_q >= AmplCntrl) ? '0 : (AmplCntrl - ampl_step_q);

   //--------------------------------------------------------------------------
   // Next-state and next-output logic
   //--------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal driven here is given a default first, so no path
      // through the case statement leaves one unassigned (no latch inferred).
      state_d      = state_q;
      freq_d       = FreqCntrl;
      ampl_d       = AmplCntrl;
      en_d         = DDSEn;
      busy_d       = Busy;
      done_d       = 1'b0;
      dwell_cnt_d  = dwell_cnt_q;
      steps_left_d = steps_left_q;
      accept       = 1'b0;

      unique case (state_q)
         IDLE: begin
            // Start together with Abort is treated as no request at all.
            if (Start && !Abort) begin
               accept  = 1'b1;
               freq_d  = FreqStart;
               ampl_d  = '0;
               en_d    = 1'b1;
               busy_d  = 1'b1;
               state_d = RAMP_UP;
            end
         end

         RAMP_UP: begin
            // On an abort edge nothing is updated; ramp-down starts from
            // whatever amplitude has been reached.
            if (Abort) begin
               state_d = RAMP_DOWN;
            end else if (AmplCntrl == ampl_target_q) begin
               dwell_cnt_d  = dwell_reload_q;
               steps_left_d = step_count_q;
               state_d      = SWEEP;
            end else begin
               ampl_d = ampl_up;
            end
         end

         SWEEP: begin
            // Each tuning word is visible for dwell_reload_q+1 SWEEP cycles;
            // the step to the next word happens on the last of those cycles.
            if (Abort) begin
               state_d = RAMP_DOWN;
            end else if (dwell_cnt_q != '0) begin
               dwell_cnt_d = dwell_cnt_q - CNT_W'(1);
            end else if (steps_left_q != '0) begin
               freq_d       = FreqCntrl + freq_step_q;
               steps_left_d = steps_left_q - CNT_W'(1);
               dwell_cnt_d  = dwell_reload_q;
            end else begin
               state_d = RAMP_DOWN;
            end
         end

         RAMP_DOWN: begin
            // Frequency stays frozen; Abort has no further effect here.
            if (AmplCntrl == '0) begin
               state_d = DONE;
            end else begin
               ampl_d = ampl_dn;
            end
         end

         DONE: begin
            en_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   //--------------------------------------------------------------------------
   // State, counters, shadow descriptor and registered outputs
   //--------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples its inputs from before the edge regardless of order.
   always_ff @(posedge AXI_clk) begin
      if (rst) begin
         state_q        <= IDLE;
         FreqCntrl      <= '0;
         AmplCntrl      <= '0;
         DDSEn          <= 1'b0;
         Busy           <= 1'b0;
         Done           <= 1'b0;
         dwell_cnt_q    <= '0;
         steps_left_q   <= '0;
         // NOTE: the shadow descriptor is reset as well. It is a handful of
         // flops, not a memory array, and a defined value keeps the
         // ramp/sweep datapath free of X after reset.
         freq_step_q    <= '0;
         step_count_q   <= '0;
         dwell_reload_q <= '0;
         ampl_target_q  <= '0;
         ampl_step_q    <= '0;
      end else begin
         state_q      <= state_d;
         FreqCntrl    <= freq_d;
         AmplCntrl    <= ampl_d;
         DDSEn        <= en_d;
         Busy         <= busy_d;
         Done         <= done_d;
         dwell_cnt_q  <= dwell_cnt_d;
         steps_left_q <= steps_left_d;

         if (accept) begin
            freq_step_q    <= FreqStep;
            step_count_q   <= StepCount;
            dwell_reload_q <= (DwellCycles == '0) ? '0 : (DwellCycles - CNT_W'(1));
            ampl_target_q  <= AmplTarget[AMPL_W-1] ? AMPL_MAX : AmplTarget;
            ampl_step_q    <= (AmplStep == '0) ? AMPL_MAX : AmplStep;
         end
      end
   end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
//-----------------------------------------------------------------------------
// tb_dds_sweep_ctrl
//
// Directed bench for dds_sweep_ctrl. Inputs are driven and outputs sampled on
// the falling clock edge. Each run is recorded cycle by cycle into cap[], where
// index k is the state of the outputs after the k-th rising edge counted from
// the edge that accepted Start. The expected traces below were worked out by
// hand from the sweep descriptors.
//-----------------------------------------------------------------------------
module tb_dds_sweep_ctrl;

   localparam int FREQ_W = 32;
   localparam int AMPL_W = 16;
   localparam int CNT_W  = 16;

   logic              AXI_clk = 1'b0;
   logic              rst;
   logic              Start;
   logic              Abort;
   logic [FREQ_W-1:0] FreqStart;
   logic [FREQ_W-1:0] FreqStep;
   logic [CNT_W-1:0]  StepCount;
   logic [CNT_W-1:0]  DwellCycles;
   logic [AMPL_W-1:0] AmplTarget;
   logic [AMPL_W-1:0] AmplStep;
   logic [FREQ_W-1:0] FreqCntrl;
   logic [AMPL_W-1:0] AmplCntrl;
   logic              DDSEn;
   logic              Busy;
   logic              Done;

   typedef struct packed {
      logic [31:0] f;
      logic [15:0] a;
      logic        en;
      logic        busy;
      logic        done;
   } obs_t;

   typedef struct packed {
      logic [31:0] fstart;
      logic [31:0] fstep;
      logic [15:0] scount;
      logic [15:0] dwell;
      logic [15:0] atarget;
      logic [15:0] astep;
   } desc_t;

   localparam desc_t NOMINAL = '{fstart: 32'd50000, fstep: 32'd1000, scount: 16'd3,
                                 dwell: 16'd4, atarget: 16'h7FFF, astep: 16'h2000};
   localparam desc_t GARBLE  = '{fstart: 32'hDEADBEEF, fstep: 32'd7, scount: 16'd9,
                                 dwell: 16'd1, atarget: 16'h1000, astep: 16'h0001};

   int   passed = 0;
   int   total  = 0;
   obs_t cap [0:63];

   dds_sweep_ctrl #(
      .FREQ_W (FREQ_W),
      .AMPL_W (AMPL_W),
      .CNT_W  (CNT_W)
   ) dut (
      .AXI_clk     (AXI_clk),
      .rst         (rst),
      .Start       (Start),
      .Abort       (Abort),
      .FreqStart   (FreqStart),
      .FreqStep    (FreqStep),
      .StepCount   (StepCount),
      .DwellCycles (DwellCycles),
      .AmplTarget  (AmplTarget),
      .AmplStep    (AmplStep),
      .FreqCntrl   (FreqCntrl),
      .AmplCntrl   (AmplCntrl),
      .DDSEn       (DDSEn),
      .Busy        (Busy),
      .Done        (Done)
   );

   always #5 AXI_clk = ~AXI_clk;

   //--------------------------------------------------------------------------
   // Helpers
   //--------------------------------------------------------------------------
   function automatic obs_t mk(input logic [31:0] f, input logic [15:0] a,
                               input logic en, input logic busy, input logic done);
      obs_t o;
      o.f = f; o.a = a; o.en = en; o.busy = busy; o.done = done;
      return o;
   endfunction

   function automatic obs_t sample();
      return mk(FreqCntrl, AmplCntrl, DDSEn, Busy, Done);
   endfunction

   function automatic string fmt(input obs_t o);
      return $sformatf("f=%h a=%h en=%b busy=%b done=%b", o.f, o.a, o.en, o.busy, o.done);
   endfunction

   task automatic drive_desc(input desc_t d);
      FreqStart   = d.fstart;
      FreqStep    = d.fstep;
      StepCount   = d.scount;
      DwellCycles = d.dwell;
      AmplTarget  = d.atarget;
      AmplStep    = d.astep;
   endtask

   // Launch a run and record n cycles of outputs. abort_at raises Abort for
   // the edge after sample k==abort_at. With garble set, Start is held high
   // and a different descriptor is driven while the run is busy.
   task automatic run_capture(input desc_t d, input int n, input int abort_at,
                              input bit garble);
      drive_desc(d);
      Start = 1'b1;
      Abort = 1'b0;
      @(negedge AXI_clk);
      Start = garble;
      if (garble) drive_desc(GARBLE);
      for (int k = 0; k < n; k++) begin
         cap[k] = sample();
         Abort  = (k == abort_at);
         if (garble && k >= 10) Start = 1'b0;
         @(negedge AXI_clk);
      end
      Abort = 1'b0;
      Start = 1'b0;
   endtask

   //--------------------------------------------------------------------------
   // Hand-derived expected traces
   //--------------------------------------------------------------------------
   // Nominal: ramp 0,2000,4000,6000,7FFF; SWEEP from k5; 50000 to k8,
   // 51000 k9-12, 52000 k13-16, 53000 k17-20; ramp-down k22-25; DONE k26;
   // Done pulse k27.
   function automatic obs_t exp_nominal(input int k);
      logic [31:0] f;
      logic [15:0] a;
      if (k <= 8)       f = 32'd50000;
      else if (k <= 12) f = 32'd51000;
      else if (k <= 16) f = 32'd52000;
      else              f = 32'd53000;
      case (k)
         0:       a = 16'h0000;
         1:       a = 16'h2000;
         2:       a = 16'h4000;
         3:       a = 16'h6000;
         22:      a = 16'h5FFF;
         23:      a = 16'h3FFF;
         24:      a = 16'h1FFF;
         default: a = (k <= 21) ? 16'h7FFF : 16'h0000;
      endcase
      return mk(f, a, k <= 26, k <= 26, k == 27);
   endfunction

   // Abort sampled on the edge ending k10 (second dwell cycle of 51000).
   function automatic obs_t exp_abort(input int k);
      logic [15:0] a;
      if (k <= 10) return exp_nominal(k);
      case (k)
         11:      a = 16'h7FFF;
         12:      a = 16'h5FFF;
         13:      a = 16'h3FFF;
         14:      a = 16'h1FFF;
         default: a = 16'h0000;
      endcase
      return mk(32'd51000, a, k <= 16, k <= 16, k == 17);
   endfunction

   // Jump ramp (step 0), dwell of one cycle, two increments.
   function automatic obs_t exp_fast(input int k, input logic [31:0] f0,
                                     input logic [31:0] f1, input logic [31:0] f2);
      logic [31:0] f;
      f = (k <= 2) ? f0 : ((k == 3) ? f1 : f2);
      return mk(f, (k >= 1 && k <= 5) ? 16'h7FFF : 16'h0000, k <= 7, k <= 7, k == 8);
   endfunction

   //--------------------------------------------------------------------------
   // Tests
   //--------------------------------------------------------------------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge AXI_clk);
      total++;
      if (sample() !== mk('0, '0, 0, 0, 0))
         $display("FAIL reset: got %s, expected all zero", fmt(sample()));
      else passed++;
      rst = 1'b0;
      @(negedge AXI_clk);
      total++;
      if (sample() !== mk('0, '0, 0, 0, 0))
         $display("FAIL reset_release: got %s, expected all zero", fmt(sample()));
      else passed++;
   endtask

   task automatic test_start_abort_idle();
      drive_desc(NOMINAL);
      Start = 1'b1;
      Abort = 1'b1;
      @(negedge AXI_clk);
      Start = 1'b0;
      Abort = 1'b0;
      for (int k = 0; k < 3; k++) begin
         total++;
         if (sample() !== mk('0, '0, 0, 0, 0))
            $display("FAIL start_abort_idle k=%0d: got %s, expected idle zeros",
                     k, fmt(sample()));
         else passed++;
         @(negedge AXI_clk);
      end
   endtask

   task automatic test_nominal();
      run_capture(NOMINAL, 29, -1, 1'b0);
      for (int k = 0; k < 29; k++) begin
         total++;
         if (cap[k] !== exp_nominal(k))
            $display("FAIL nominal k=%0d: got %s, expected %s",
                     k, fmt(cap[k]), fmt(exp_nominal(k)));
         else passed++;
      end
   endtask

   task automatic test_abort();
      run_capture(NOMINAL, 19, 10, 1'b0);
      for (int k = 0; k < 19; k++) begin
         total++;
         if (cap[k] !== exp_abort(k))
            $display("FAIL abort k=%0d: got %s, expected %s",
                     k, fmt(cap[k]), fmt(exp_abort(k)));
         else passed++;
      end
   endtask

   task automatic test_wrap();
      desc_t d;
      d = '{fstart: 32'hFFFFFF00, fstep: 32'h100, scount: 16'd2,
            dwell: 16'd1, atarget: 16'h7FFF, astep: 16'h0000};
      run_capture(d, 10, -1, 1'b0);
      for (int k = 0; k < 10; k++) begin
         total++;
         if (cap[k] !== exp_fast(k, 32'hFFFFFF00, 32'h0, 32'h100))
            $display("FAIL wrap k=%0d: got %s, expected %s", k, fmt(cap[k]),
                     fmt(exp_fast(k, 32'hFFFFFF00, 32'h0, 32'h100)));
         else passed++;
      end
   endtask

   // Negative step, plus target 0x8000 (clamps to 0x7FFF) and dwell 0.
   task automatic test_negative_step();
      desc_t d;
      d = '{fstart: 32'd251658, fstep: 32'hFFFFFC18, scount: 16'd2,
            dwell: 16'd0, atarget: 16'h8000, astep: 16'h0000};
      run_capture(d, 10, -1, 1'b0);
      for (int k = 0; k < 10; k++) begin
         total++;
         if (cap[k] !== exp_fast(k, 32'd251658, 32'd250658, 32'd249658))
            $display("FAIL negative_step k=%0d: got %s, expected %s", k, fmt(cap[k]),
                     fmt(exp_fast(k, 32'd251658, 32'd250658, 32'd249658)));
         else passed++;
      end
   endtask

   // Target 0 and StepCount 0: one RAMP_UP cycle, two SWEEP cycles at 1234.
   task automatic test_zero_target();
      desc_t d;
      d = '{fstart: 32'd1234, fstep: 32'd5, scount: 16'd0,
            dwell: 16'd2, atarget: 16'h0000, astep: 16'h0100};
      run_capture(d, 7, -1, 1'b0);
      for (int k = 0; k < 7; k++) begin
         total++;
         if (cap[k] !== mk(32'd1234, 16'h0, k <= 4, k <= 4, k == 5))
            $display("FAIL zero_target k=%0d: got %s, expected %s", k, fmt(cap[k]),
                     fmt(mk(32'd1234, 16'h0, k <= 4, k <= 4, k == 5)));
         else passed++;
      end
   endtask

   task automatic test_start_while_busy();
      run_capture(NOMINAL, 29, -1, 1'b1);
      for (int k = 0; k < 29; k++) begin
         total++;
         if (cap[k] !== exp_nominal(k))
            $display("FAIL start_while_busy k=%0d: got %s, expected %s",
                     k, fmt(cap[k]), fmt(exp_nominal(k)));
         else passed++;
      end
   endtask

   task automatic test_reset_mid_sweep();
      drive_desc(NOMINAL);
      Start = 1'b1;
      @(negedge AXI_clk);
      Start = 1'b0;
      repeat (7) @(negedge AXI_clk);
      total++;
      if (sample() !== mk(32'd50000, 16'h7FFF, 1, 1, 0))
         $display("FAIL pre_reset_sweep: got %s, expected %s", fmt(sample()),
                  fmt(mk(32'd50000, 16'h7FFF, 1, 1, 0)));
      else passed++;
      rst = 1'b1;
      @(negedge AXI_clk);
      total++;
      if (sample() !== mk('0, '0, 0, 0, 0))
         $display("FAIL reset_mid_sweep: got %s, expected all zero", fmt(sample()));
      else passed++;
      rst = 1'b0;
      @(negedge AXI_clk);
      total++;
      if (sample() !== mk('0, '0, 0, 0, 0))
         $display("FAIL reset_mid_sweep_idle: got %s, expected all zero", fmt(sample()));
      else passed++;
      run_capture(NOMINAL, 29, -1, 1'b0);
      for (int k = 0; k < 29; k++) begin
         total++;
         if (cap[k] !== exp_nominal(k))
            $display("FAIL after_reset_run k=%0d: got %s, expected %s",
                     k, fmt(cap[k]), fmt(exp_nominal(k)));
         else passed++;
      end
   endtask

   initial begin
      rst   = 1'b1;
      Start = 1'b0;
      Abort = 1'b0;
      drive_desc('0);
      test_reset();
      test_start_abort_idle();
      test_nominal();
      test_abort();
      test_wrap();
      test_negative_step();
      test_zero_target();
      test_start_while_busy();
      test_reset_mid_sweep();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
